// File: rtl/key_seq_unlock_if.sv
// key_seq_unlock_if: bus between the challenger/consumer and key_seq_unlock.
//
// Signals:
//   key        challenger -> gate   key word
//   key_valid  challenger -> gate   key word present this cycle
//   data       gate -> consumer     secret word (0 when data_valid=0)
//   data_valid gate -> consumer     secret word available
//   data_ready consumer -> gate     consumer accepts data this cycle
//
// Handshake: a key word is consumed on any rising edge where key_valid=1
// (no backpressure on keys). A secret word transfers on a rising edge where
// data_valid=1 and data_ready=1; while data_ready=0 the gate holds data and
// data_valid stable.
//
// Modports:
//   master  the challenger/consumer side (drives key, key_valid, data_ready)
//   slave   the gate side (drives data, data_valid)
interface key_seq_unlock_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic [WIDTH-1:0] key;
  logic             key_valid;
  logic [WIDTH-1:0] data;
  logic             data_valid;
  logic             data_ready;

  modport master (
    output key,
    output key_valid,
    output data_ready,
    input  data,
    input  data_valid
  );

  modport slave (
    input  key,
    input  key_valid,
    input  data_ready,
    output data,
    output data_valid
  );
endinterface

// File: rtl/key_seq_unlock.sv
// key_seq_unlock: multi-word key sequence gate with timed lockout.
//
// A KEY_LEN-word unlock sequence arrives word by word on bus.key/key_valid.
// A full match streams DATA_LEN secret words out on bus.data/data_valid with
// a valid/ready handshake. MAX_FAILS consecutive mismatches put the gate into
// a LOCKOUT that lasts LOCKOUT_CYCLES clocks, during which keys are ignored.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   bus        key_seq_unlock_if.slave (key, key_valid, data, data_valid,
//              data_ready)
//   unlocked   high while in EMIT
//   locked_out high while in LOCKOUT
//   fail_count current consecutive-failure count
//   dbg_state  current FSM state (0=COLLECT, 1=EMIT, 2=LOCKOUT)
//
// All outputs are registered.
module key_seq_unlock #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned KEY_LEN        = 2,
  parameter logic [KEY_LEN*WIDTH-1:0] KEYS = {32'h12345678, 32'h9DA79FF0},
  parameter int unsigned DATA_LEN       = 2,
  parameter logic [DATA_LEN*WIDTH-1:0] SECRET = {32'h0001017F, 32'h00464C45},
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  localparam int unsigned FC_W          = $clog2(MAX_FAILS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  key_seq_unlock_if.slave     bus,
  output logic                unlocked,
  output logic                locked_out,
  output logic [FC_W-1:0]     fail_count,
  output logic [1:0]          dbg_state
);

  // Counters keep at least one bit so single-word configurations elaborate.
  localparam int unsigned IDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int unsigned PTR_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
  localparam int unsigned TMR_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_EMIT    = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [PTR_W-1:0] ptr;
  logic [FC_W-1:0]  fails;
  logic [TMR_W-1:0] timer;
  logic [WIDTH-1:0] data_q;
  logic             data_valid_q;
  logic             unlocked_q;
  logic             locked_out_q;

  logic [WIDTH-1:0] key_word;
  logic [WIDTH-1:0] secret_next;
  logic             key_match;
  logic             idx_last;
  logic             ptr_last;
  logic             fail_below;

  // Expected key word for the current position, and the secret word that
  // follows the one currently on the bus. secret_next is only used when
  // ptr is not the last word, so the part-select stays in range.
  always_comb begin
    key_word    = KEYS[32'(idx) * WIDTH +: WIDTH];
    secret_next = '0;
    if (!ptr_last) begin
      secret_next = SECRET[(32'(ptr) + 32'd1) * WIDTH +: WIDTH];
    end
  end

  assign key_match  = (bus.key == key_word);
  assign idx_last   = (idx == IDX_W'(KEY_LEN - 1));
  assign ptr_last   = (ptr == PTR_W'(DATA_LEN - 1));
  // True when one more mismatch still leaves us short of lockout.
  assign fail_below = ((32'(fails) + 32'd1) < MAX_FAILS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_COLLECT;
      idx          <= '0;
      ptr          <= '0;
      fails        <= '0;
      timer        <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (bus.key_valid) begin
            if (key_match) begin
              if (idx_last) begin
                state        <= ST_EMIT;
                idx          <= '0;
                ptr          <= '0;
                fails        <= '0;
                data_q       <= SECRET[WIDTH-1:0];
                data_valid_q <= 1'b1;
                unlocked_q   <= 1'b1;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end else begin
              // The offending word is dropped, not retried as a first word.
              idx <= '0;
              if (fail_below) begin
                fails <= fails + FC_W'(1);
              end else begin
                state        <= ST_LOCKOUT;
                timer        <= TMR_W'(LOCKOUT_CYCLES - 1);
                fails        <= FC_W'(MAX_FAILS);
                locked_out_q <= 1'b1;
              end
            end
          end
        end

        ST_EMIT: begin
          if (bus.data_ready) begin
            if (!ptr_last) begin
              ptr    <= ptr + PTR_W'(1);
              data_q <= secret_next;
            end else begin
              state        <= ST_COLLECT;
              ptr          <= '0;
              data_q       <= '0;
              data_valid_q <= 1'b0;
              unlocked_q   <= 1'b0;
            end
          end
        end

        ST_LOCKOUT: begin
          // timer starts at LOCKOUT_CYCLES-1, so the state lasts exactly
          // LOCKOUT_CYCLES cycles including the one where timer reads 0.
          if (timer == '0) begin
            state        <= ST_COLLECT;
            fails        <= '0;
            locked_out_q <= 1'b0;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end

        default: begin
          state        <= ST_COLLECT;
          idx          <= '0;
          ptr          <= '0;
          fails        <= '0;
          timer        <= '0;
          data_q       <= '0;
          data_valid_q <= 1'b0;
          unlocked_q   <= 1'b0;
          locked_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign unlocked       = unlocked_q;
  assign locked_out     = locked_out_q;
  assign fail_count     = fails;
  assign dbg_state      = state;

endmodule

// File: tb/tb_key_seq_unlock.sv
module tb_key_seq_unlock;

  localparam logic [31:0] K0 = 32'h9DA79FF0;
  localparam logic [31:0] K1 = 32'h12345678;
  localparam logic [31:0] S0 = 32'h00464C45;
  localparam logic [31:0] S1 = 32'h0001017F;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       unlocked;
  logic       locked_out;
  logic [1:0] fail_count;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  key_seq_unlock_if #(.WIDTH(32)) bus ();

  key_seq_unlock dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .fail_count (fail_count),
    .dbg_state  (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Snapshot: {data_valid, data, unlocked, locked_out, fail_count}
  logic [36:0] obs;
  assign obs = {bus.data_valid, bus.data, unlocked, locked_out, fail_count};

  localparam logic [36:0] IDLE0  = {1'b0, 32'h0, 1'b0, 1'b0, 2'd0};
  localparam logic [36:0] IDLE1  = {1'b0, 32'h0, 1'b0, 1'b0, 2'd1};
  localparam logic [36:0] IDLE2  = {1'b0, 32'h0, 1'b0, 1'b0, 2'd2};
  localparam logic [36:0] LOCKED = {1'b0, 32'h0, 1'b0, 1'b1, 2'd3};
  localparam logic [36:0] EMIT0  = {1'b1, S0, 1'b1, 1'b0, 2'd0};
  localparam logic [36:0] EMIT1  = {1'b1, S1, 1'b1, 1'b0, 2'd0};

  // Driver tasks: inputs change 1 time unit after the rising edge,
  // outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_key(input logic [31:0] k, input logic v);
    bus.key       = k;
    bus.key_valid = v;
    tick();
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.key_valid  = 1'b0;
    bus.key        = '0;
    bus.data_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs !== IDLE0) begin
      n_fail++;
      $display("FAIL reset_outputs obs=%h exp=%h", obs, IDLE0);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
  endtask

  task automatic test_happy();
    do_reset();
    bus.data_ready = 1'b1;
    drive_key(K0, 1'b1);
    n_checks++;
    if (obs !== IDLE0) begin
      n_fail++;
      $display("FAIL happy_first_word obs=%h exp=%h", obs, IDLE0);
    end
    drive_key(K1, 1'b1);
    n_checks++;
    if (obs !== EMIT0) begin
      n_fail++;
      $display("FAIL happy_emit0 obs=%h exp=%h", obs, EMIT0);
    end
    drive_key('0, 1'b0);
    n_checks++;
    if (obs !== EMIT1) begin
      n_fail++;
      $display("FAIL happy_emit1 obs=%h exp=%h", obs, EMIT1);
    end
    tick();
    n_checks++;
    if (obs !== IDLE0) begin
      n_fail++;
      $display("FAIL happy_done obs=%h exp=%h", obs, IDLE0);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.data_ready = 1'b0;
    drive_key(K0, 1'b1);
    drive_key(K1, 1'b1);
    bus.key_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (obs !== EMIT0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d obs=%h exp=%h", i, obs, EMIT0);
      end
      tick();
    end
    n_checks++;
    if (obs !== EMIT0) begin
      n_fail++;
      $display("FAIL bp_hold_end obs=%h exp=%h", obs, EMIT0);
    end
    bus.data_ready = 1'b1;
    tick();
    n_checks++;
    if (obs !== EMIT1) begin
      n_fail++;
      $display("FAIL bp_advance obs=%h exp=%h", obs, EMIT1);
    end
    bus.data_ready = 1'b0;
    tick();
    n_checks++;
    if (obs !== EMIT1) begin
      n_fail++;
      $display("FAIL bp_hold_last obs=%h exp=%h", obs, EMIT1);
    end
    bus.data_ready = 1'b1;
    tick();
    n_checks++;
    if (obs !== IDLE0) begin
      n_fail++;
      $display("FAIL bp_done obs=%h exp=%h", obs, IDLE0);
    end
  endtask

  task automatic test_sequence_break();
    do_reset();
    bus.data_ready = 1'b1;
    drive_key(K0, 1'b1);
    drive_key(32'hDEADBEEF, 1'b1);
    n_checks++;
    if (obs !== IDLE1) begin
      n_fail++;
      $display("FAIL break_second obs=%h exp=%h", obs, IDLE1);
    end
    drive_key(K1, 1'b1);
    n_checks++;
    if (obs !== IDLE2) begin
      n_fail++;
      $display("FAIL break_third obs=%h exp=%h", obs, IDLE2);
    end
    drive_key('0, 1'b0);
    n_checks++;
    if (obs !== IDLE2) begin
      n_fail++;
      $display("FAIL break_no_unlock obs=%h exp=%h", obs, IDLE2);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    bus.data_ready = 1'b1;
    drive_key(K0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_key(K1, 1'b0);
      n_checks++;
      if (obs !== IDLE0) begin
        n_fail++;
        $display("FAIL gap_idle_%0d obs=%h exp=%h", i, obs, IDLE0);
      end
    end
    drive_key(K1, 1'b1);
    n_checks++;
    if (obs !== EMIT0) begin
      n_fail++;
      $display("FAIL gap_unlock obs=%h exp=%h", obs, EMIT0);
    end
    drive_key('0, 1'b0);
    tick();
  endtask

  task automatic test_lockout();
    do_reset();
    bus.data_ready = 1'b1;
    drive_key(32'h0, 1'b1);
    drive_key(32'h1, 1'b1);
    drive_key(32'h2, 1'b1);
    // 16 observed cycles of lockout while the correct sequence is offered.
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (obs !== LOCKED) begin
        n_fail++;
        $display("FAIL lock_cycle_%0d obs=%h exp=%h", i, obs, LOCKED);
      end
      drive_key((i % 2 == 0) ? K0 : K1, 1'b1);
    end
    bus.key_valid = 1'b0;
    n_checks++;
    if (obs !== IDLE0) begin
      n_fail++;
      $display("FAIL lock_exit obs=%h exp=%h", obs, IDLE0);
    end
    drive_key(K0, 1'b1);
    drive_key(K1, 1'b1);
    n_checks++;
    if (obs !== EMIT0) begin
      n_fail++;
      $display("FAIL lock_then_unlock obs=%h exp=%h", obs, EMIT0);
    end
    drive_key('0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_emit();
    do_reset();
    bus.data_ready = 1'b1;
    drive_key(K0, 1'b1);
    drive_key(K1, 1'b1);
    drive_key('0, 1'b0);
    n_checks++;
    if (obs !== EMIT1) begin
      n_fail++;
      $display("FAIL rst_emit_pre obs=%h exp=%h", obs, EMIT1);
    end
    rst            = 1'b1;
    bus.data_ready = 1'b0;
    tick();
    rst = 1'b0;
    n_checks++;
    if (obs !== IDLE0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_emit_cleared obs=%h state=%0d exp=%h state=0", obs, dbg_state, IDLE0);
    end
    bus.data_ready = 1'b1;
    drive_key(K1, 1'b1);
    n_checks++;
    if (obs !== IDLE1) begin
      n_fail++;
      $display("FAIL rst_emit_partial obs=%h exp=%h", obs, IDLE1);
    end
    drive_key(K0, 1'b1);
    drive_key(K1, 1'b1);
    n_checks++;
    if (obs !== EMIT0) begin
      n_fail++;
      $display("FAIL rst_emit_fresh obs=%h exp=%h", obs, EMIT0);
    end
    drive_key('0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_lockout();
    do_reset();
    bus.data_ready = 1'b1;
    drive_key(32'h0, 1'b1);
    drive_key(32'h1, 1'b1);
    drive_key(32'h2, 1'b1);
    bus.key_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (obs !== LOCKED) begin
      n_fail++;
      $display("FAIL rst_lock_cycle5 obs=%h exp=%h", obs, LOCKED);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (obs !== IDLE0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_lock_cleared obs=%h state=%0d exp=%h state=0", obs, dbg_state, IDLE0);
    end
    drive_key(K0, 1'b1);
    drive_key(K1, 1'b1);
    n_checks++;
    if (obs !== EMIT0) begin
      n_fail++;
      $display("FAIL rst_lock_fresh obs=%h exp=%h", obs, EMIT0);
    end
    drive_key('0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.data_ready = 1'b1;
    drive_key(K0, 1'b1);
    drive_key(K1, 1'b1);
    // Keys keep arriving every cycle while EMIT runs; they must be ignored.
    drive_key(K0, 1'b1);
    n_checks++;
    if (obs !== EMIT1) begin
      n_fail++;
      $display("FAIL b2b_emit1 obs=%h exp=%h", obs, EMIT1);
    end
    drive_key(K1, 1'b1);
    n_checks++;
    if (obs !== IDLE0) begin
      n_fail++;
      $display("FAIL b2b_ignored obs=%h exp=%h", obs, IDLE0);
    end
    drive_key(K0, 1'b1);
    drive_key(K1, 1'b1);
    n_checks++;
    if (obs !== EMIT0) begin
      n_fail++;
      $display("FAIL b2b_second_unlock obs=%h exp=%h", obs, EMIT0);
    end
    drive_key('0, 1'b0);
    tick();
  endtask

  initial begin
    bus.key        = '0;
    bus.key_valid  = 1'b0;
    bus.data_ready = 1'b0;
    test_reset();
    test_happy();
    test_backpressure();
    test_sequence_break();
    test_gaps();
    test_lockout();
    test_reset_mid_emit();
    test_reset_mid_lockout();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
